// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcs4_pkg
//  Description : Shared types and constants for the MCS-4 RAM/IO bus master:
//                instruction-cycle phases, RAM/IO opcodes, OPR constants,
//                master state encoding and the read-class opcode decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcs4_pkg;

    // Eight clk phases of one MCS-4 instruction cycle
    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    // RAM/IO group opcodes carried in the OPA nibble after OPR=E
    typedef enum logic [3:0] {
        WRM = 4'h0,
        WMP = 4'h1,
        WRR = 4'h2,
        WPM = 4'h3,
        WR0 = 4'h4,
        WR1 = 4'h5,
        WR2 = 4'h6,
        WR3 = 4'h7,
        SBM = 4'h8,
        RDM = 4'h9,
        RDR = 4'hA,
        ADM = 4'hB,
        RD0 = 4'hC,
        RD1 = 4'hD,
        RD2 = 4'hE,
        RD3 = 4'hF
    } ioram_opa_t;

    localparam logic [3:0] OPR_SRC = 4'h2;
    localparam logic [3:0] OPR_IO  = 4'hE;

    // Kind of instruction cycle the master is currently issuing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRC  = 2'd1,
        ST_IO   = 2'd2
    } mst_state_t;

    // The upper half of the opcode space returns data on the bus
    function automatic logic is_read_op(input ioram_opa_t op);
        return op[3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcs4_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mcs4_timing_gen
//  Description : Free-running MCS-4 instruction-cycle phase counter with
//                sync decode. Reset parks the counter at X3 so that sync is
//                asserted during reset and A1 follows release.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcs4_timing_gen
    import mcs4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output instr_cyc_t phase_o,
    output logic       sync_o
);

    logic [2:0] phase_q;
    logic [2:0] phase_d;

    // Next phase: wraps X3 -> A1 naturally through 3-bit overflow
    always_comb begin
        phase_d = phase_q + 3'd1;
    end

    // Phase register, parked at X3 during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 3'd7;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = instr_cyc_t'(phase_q);
    assign sync_o  = (phase_q == 3'd7);

endmodule
`default_nettype wire

// File: rtl/mcs4_ram_master.sv
`default_nettype none
// ============================================================================
//  Module      : mcs4_ram_master
//  Description : MCS-4 RAM/IO bus initiator. Turns a request/response
//                handshake into an SRC instruction cycle followed by one I/O
//                instruction cycle, capturing the returned nibble for reads.
//                Optional macro MCS4_MASTER_SRC_CACHE_EN skips the SRC cycle
//                when the request address matches the last one issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcs4_ram_master
    import mcs4_pkg::*;
#(
    parameter logic [3:0] IDLE_OPR = 4'h0,
    parameter logic [2:0] SRC_PAIR = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [1:0] req_chip,
    input  logic [1:0] req_reg,
    input  logic [3:0] req_char,
    input  logic [3:0] req_wdata,
    output logic       rsp_valid,
    output logic [3:0] rsp_rdata,
    output logic       sync,
    output logic       cm_ram,
    output logic [3:0] dbus_out,
    input  logic [3:0] dbus_in
);

    instr_cyc_t phase;
    mst_state_t state_q, state_d;
    logic       pending_q, pending_d;
    ioram_opa_t op_q;
    logic [1:0] chip_q, reg_q;
    logic [3:0] char_q, wdata_q;
    logic [3:0] rdata_q, rdata_d;
    logic       accept, at_x3, launch, hit;

    mcs4_timing_gen u_timing (
        .clk     (clk),
        .rst     (rst),
        .phase_o (phase),
        .sync_o  (sync)
    );

    // A request may only start at an instruction-cycle boundary; it is
    // launched at X3 either from the holding register or straight from the
    // port when it arrives in that very X3.
    assign at_x3     = (phase == X3);
    assign req_ready = !pending_q && ((state_q == ST_IDLE) || ((state_q == ST_IO) && at_x3));
    assign accept    = req_valid && req_ready;
    assign launch    = at_x3 && (pending_q || accept);
    assign rsp_valid = (state_q == ST_IO) && at_x3;
    assign rsp_rdata = rdata_q;

`ifdef MCS4_MASTER_SRC_CACHE_EN
    logic       cvalid_q;
    logic [7:0] caddr_q;
    logic [7:0] launch_addr;

    assign launch_addr = accept ? {req_chip, req_reg, req_char} : {chip_q, reg_q, char_q};
    assign hit         = cvalid_q && (caddr_q == launch_addr);

    // Remember the address of every SRC actually placed on the bus
    always_ff @(posedge clk) begin
        if (rst) begin
            cvalid_q <= 1'b0;
            caddr_q  <= 8'h00;
        end else if (launch && !hit) begin
            cvalid_q <= 1'b1;
            caddr_q  <= launch_addr;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Next state, pending flag and read capture
    always_comb begin
        state_d   = state_q;
        pending_d = (pending_q || accept) && !launch;
        rdata_d   = rdata_q;
        if (at_x3) begin
            case (state_q)
                ST_IDLE: if (launch) state_d = hit ? ST_IO : ST_SRC;
                ST_SRC:  state_d = ST_IO;
                ST_IO:   state_d = launch ? (hit ? ST_IO : ST_SRC) : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        if ((state_q == ST_IO) && (phase == X2)) begin
            rdata_d = is_read_op(op_q) ? dbus_in : 4'h0;
        end
    end

    // State, request fields and response data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            rdata_q   <= 4'h0;
            op_q      <= WRM;
            chip_q    <= 2'd0;
            reg_q     <= 2'd0;
            char_q    <= 4'h0;
            wdata_q   <= 4'h0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            if (accept) begin
                op_q    <= ioram_opa_t'(req_op);
                chip_q  <= req_chip;
                reg_q   <= req_reg;
                char_q  <= req_char;
                wdata_q <= req_wdata;
            end
        end
    end

    // Bus drive per phase and instruction-cycle type
    always_comb begin
        dbus_out = 4'h0;
        cm_ram   = 1'b0;
        case (phase)
            M1: begin
                case (state_q)
                    ST_SRC:  dbus_out = OPR_SRC;
                    ST_IO:   dbus_out = OPR_IO;
                    default: dbus_out = IDLE_OPR;
                endcase
            end
            M2: begin
                case (state_q)
                    ST_SRC: dbus_out = {SRC_PAIR, 1'b1};
                    ST_IO: begin
                        dbus_out = op_q;
                        cm_ram   = 1'b1;
                    end
                    default: dbus_out = 4'h0;
                endcase
            end
            X2: begin
                if (state_q == ST_SRC) begin
                    dbus_out = {chip_q, reg_q};
                    cm_ram   = 1'b1;
                end else if ((state_q == ST_IO) && !is_read_op(op_q)) begin
                    dbus_out = wdata_q;
                end
            end
            X3: begin
                if (state_q == ST_SRC) begin
                    dbus_out = char_q;
                end
            end
            default: begin
                dbus_out = 4'h0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mcs4_ram_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcs4_ram_master
//  Description : Directed bench for mcs4_ram_master with a small i4002-style
//                responder (chip 2) modelled on the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcs4_ram_master;

    localparam logic [3:0] TB_IDLE_OPR = 4'h6;
`ifdef MCS4_MASTER_SRC_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'h0;
    logic [1:0] req_chip = 2'd0;
    logic [1:0] req_reg = 2'd0;
    logic [3:0] req_char = 4'h0;
    logic [3:0] req_wdata = 4'h0;
    logic       rsp_valid;
    logic [3:0] rsp_rdata;
    logic       sync;
    logic       cm_ram;
    logic [3:0] dbus_out;
    logic [3:0] dbus_in;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    mcs4_ram_master #(.IDLE_OPR(TB_IDLE_OPR), .SRC_PAIR(3'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_chip  (req_chip),
        .req_reg   (req_reg),
        .req_char  (req_char),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sync      (sync),
        .cm_ram    (cm_ram),
        .dbus_out  (dbus_out),
        .dbus_in   (dbus_in)
    );

    // Reference phase: X3 in reset, A1 after release, then counts up
    logic [2:0] ph = 3'd7;
    always @(posedge clk) begin
        if (rst) ph <= 3'd7;
        else     ph <= ph + 3'd1;
    end

    // i4002-style responder at chip 2
    logic [3:0] last_opr = 4'h0;
    logic [3:0] io_op    = 4'h0;
    logic [1:0] s_chip   = 2'd0;
    logic [1:0] s_reg    = 2'd0;
    logic [3:0] s_char   = 4'h0;
    logic [3:0] src_x2   = 4'h0;
    logic [3:0] src_x3   = 4'h0;
    int         src_cnt  = 0;
    logic [3:0] mem  [0:3][0:15] = '{default: 4'h0};
    logic [3:0] stat [0:3][0:3]  = '{default: 4'h0};

    always @(posedge clk) begin
        if (ph == 3'd3) last_opr <= dbus_out;
        if (ph == 3'd4 && last_opr == 4'hE) io_op <= dbus_out;
        if (ph == 3'd6 && last_opr == 4'h2 && cm_ram) begin
            s_chip  <= dbus_out[3:2];
            s_reg   <= dbus_out[1:0];
            src_x2  <= dbus_out;
            src_cnt <= src_cnt + 1;
        end
        if (ph == 3'd7 && last_opr == 4'h2) begin
            s_char <= dbus_out;
            src_x3 <= dbus_out;
        end
        if (ph == 3'd6 && last_opr == 4'hE && !io_op[3] && s_chip == 2'd2) begin
            if (io_op == 4'h0)       mem[s_reg][s_char]      <= dbus_out;
            else if (io_op >= 4'h4)  stat[s_reg][io_op[1:0]] <= dbus_out;
        end
    end

    assign dbus_in = (ph == 3'd6 && last_opr == 4'hE && io_op[3] && s_chip == 2'd2) ?
                     ((io_op == 4'h9) ? mem[s_reg][s_char] :
                      (io_op >= 4'hC) ? stat[s_reg][io_op[1:0]] : 4'h0) : 4'h0;

    // Bench-side copy of the SRC address cache
    logic       mv = 1'b0;
    logic [7:0] maddr = 8'h00;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            check("reset_outs", {sync, req_ready, rsp_valid, cm_ram, dbus_out, rsp_rdata}, 12'hC00);
        end
        rst = 1'b0;
        mv  = 1'b0;
    endtask

    // Wait for phase acc_ph with req_ready, present one request, and check
    // latency, returned data and whether an SRC cycle appeared on the bus.
    task automatic do_req(input logic [3:0] op, input logic [1:0] chip, input logic [1:0] rg,
                          input logic [3:0] ch, input logic [3:0] wd, input logic [2:0] acc_ph,
                          input logic [3:0] exp_rd, input string tag);
        int n;
        int src0;
        int exp_lat;
        bit hit;
        hit     = CACHE && mv && (maddr == {chip, rg, ch});
        exp_lat = (7 - int'(acc_ph)) + (hit ? 8 : 16);
        if (!hit) begin
            mv    = 1'b1;
            maddr = {chip, rg, ch};
        end
        n = 0;
        while (!(ph == acc_ph && req_ready) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_ready_wait"}, n < 200, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_chip  = chip;
        req_reg   = rg;
        req_char  = ch;
        req_wdata = wd;
        src0      = src_cnt;
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_src_cycles"}, src_cnt - src0, hit ? 0 : 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  m;
        int  pulses;
        bit  hit;

        do_reset(3);

        // Idle bus: sync every 8th clk, NOP cycles only
        for (int i = 0; i < 16; i++) begin
            step();
            check("idle_sync", sync, (ph == 3'd7));
            check("idle_cm_ram", cm_ram, 0);
            check("idle_dbus", dbus_out, (ph == 3'd3) ? TB_IDLE_OPR : 4'h0);
        end

        // Main RAM write/read and status write/read
        do_req(4'h0, 2'd2, 2'd1, 4'h5, 4'hA, 3'd7, 4'h0, "wrm");
        check("src_x2_addr", src_x2, 4'h9);
        check("src_x3_char", src_x3, 4'h5);
        do_req(4'h9, 2'd2, 2'd1, 4'h5, 4'h0, 3'd7, 4'hA, "rdm");
        do_req(4'h6, 2'd2, 2'd3, 4'h0, 4'h7, 3'd7, 4'h0, "wr2");
        do_req(4'hE, 2'd2, 2'd3, 4'h0, 4'h0, 3'd7, 4'h7, "rd2");
        do_req(4'hE, 2'd1, 2'd3, 4'h0, 4'h0, 3'd7, 4'h0, "rd2_nochip");
        do_req(4'h9, 2'd2, 2'd1, 4'h5, 4'h0, 3'd1, 4'hA, "rdm_a2");

        // req_valid held high: second request accepted in IO X3
        hit = CACHE && mv && (maddr == {2'd2, 2'd1, 4'h5});
        mv    = 1'b1;
        maddr = {2'd2, 2'd1, 4'h5};
        n = 0;
        while (!(ph == 3'd7 && req_ready) && n < 200) begin
            step();
            n++;
        end
        req_valid = 1'b1;
        req_op    = 4'h9;
        req_chip  = 2'd2;
        req_reg   = 2'd1;
        req_char  = 4'h5;
        step();
        n = 1;
        while (!rsp_valid && n < 100) begin
            step();
            n++;
        end
        check("b2b_first_latency", n, hit ? 8 : 16);
        check("b2b_first_rdata", rsp_rdata, 4'hA);
        check("b2b_ready_in_io_x3", req_ready, 1);
        step();
        m = 1;
        while (!rsp_valid && m < 100) begin
            step();
            m++;
        end
        req_valid = 1'b0;
        check("b2b_second_latency", m, CACHE ? 8 : 16);
        check("b2b_second_rdata", rsp_rdata, 4'hA);
        step();

        // Reset during IO M2 of a read aborts it silently
        n = 0;
        while (!(ph == 3'd7 && req_ready) && n < 200) begin
            step();
            n++;
        end
        req_valid = 1'b1;
        req_op    = 4'hE;
        req_chip  = 2'd2;
        req_reg   = 2'd3;
        req_char  = 4'h0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check("abort_io_m2_dbus", dbus_out, 4'hE);
        check("abort_io_m2_cm_ram", cm_ram, 1);
        do_reset(2);
        step();
        check("a1_after_release_sync", sync, 0);
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            if (rsp_valid) pulses++;
            check("post_abort_sync", sync, (ph == 3'd7));
            step();
        end
        check("abort_no_response", pulses, 0);
        do_req(4'hE, 2'd2, 2'd3, 4'h0, 4'h0, 3'd7, 4'h7, "rd2_after_rst");

        // Repeated address: SRC skipped only when the cache is built in
        do_req(4'h9, 2'd2, 2'd1, 4'h5, 4'h0, 3'd7, 4'hA, "cache_first");
        do_req(4'h9, 2'd2, 2'd1, 4'h5, 4'h0, 3'd7, 4'hA, "cache_second");
        do_reset(2);
        do_req(4'h9, 2'd2, 2'd1, 4'h5, 4'h0, 3'd7, 4'hA, "cache_after_rst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
